// File: rtl/io_map_pkg.sv
// Shared types and the default peripheral address map for the IO router.
package io_map_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic [ADDR_W-1:0] base;
        logic [ADDR_W-1:0] limit;
    } io_region_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    localparam int IO_MAP_N = 4;

    // Index order is priority order: lower index wins on overlap.
    localparam io_region_t IO_MAP [IO_MAP_N] = '{
        '{base: 32'h0200_0000, limit: 32'h03FF_FFFF},   // dmem
        '{base: 32'h0400_0000, limit: 32'h0400_0000},   // gpio0
        '{base: 32'h0400_0004, limit: 32'h0400_0009},   // uart
        '{base: 32'h0400_000A, limit: 32'h0400_000F}    // i2c
    };

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_region_decode.sv
// Combinational address decoder: hit flag, one-hot select, region index and region-relative offset.
module io_region_decode
    import io_map_pkg::*;
#(
    parameter int         NUM_IO           = 4,
    parameter io_region_t REGIONS [NUM_IO] = IO_MAP,
    parameter int         IDX_W            = idx_width(NUM_IO)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              hit,
    output logic [NUM_IO-1:0] onehot,
    output logic [IDX_W-1:0]  idx,
    output logic [ADDR_W-1:0] offset
);

    // Scan from the top down so the lowest matching index is the one left standing.
    always_comb begin
        hit    = 1'b0;
        onehot = '0;
        idx    = '0;
        offset = '0;
        for (int i = NUM_IO - 1; i >= 0; i--) begin
            if ((addr >= REGIONS[i].base) && (addr <= REGIONS[i].limit)) begin
                hit       = 1'b1;
                onehot    = '0;
                onehot[i] = 1'b1;
                idx       = i[IDX_W-1:0];
                offset    = addr - REGIONS[i].base;
            end
        end
    end

endmodule

// File: rtl/io_router.sv
// CPU-to-peripheral router: decodes a request, holds one peripheral access open, returns a one-cycle response.
// Optional access timeout enabled by defining IO_ROUTER_TIMEOUT_EN.
module io_router
    import io_map_pkg::*;
#(
    parameter int         NUM_IO           = 4,
    parameter io_region_t REGIONS [NUM_IO] = IO_MAP,
    parameter int         TIMEOUT          = 255
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [ADDR_W-1:0]        req_addr,
    input  logic                     req_we,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     rsp_valid,
    output logic [DATA_W-1:0]        rsp_rdata,
    output logic                     rsp_err,
    output logic [NUM_IO-1:0]        io_sel,
    output logic [ADDR_W-1:0]        io_addr,
    output logic                     io_we,
    output logic [DATA_W-1:0]        io_wdata,
    input  logic [NUM_IO*DATA_W-1:0] io_rdata,
    input  logic [NUM_IO-1:0]        io_ready
);

    localparam int IDX_W = idx_width(NUM_IO);

    if (NUM_IO < 1 || NUM_IO > 16 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_param_check
        $error("io_router: NUM_IO must be 1..16 and TIMEOUT 1..65535");
    end

    state_t              state, state_nxt;
    logic                dec_hit;
    logic [NUM_IO-1:0]   dec_onehot;
    logic [IDX_W-1:0]    dec_idx;
    logic [ADDR_W-1:0]   dec_offset;
    logic [IDX_W-1:0]    sel_idx;
    logic                sel_ready;
    logic                tmo_hit;
    logic [DATA_W-1:0]   rd_slice;

    io_region_decode #(
        .NUM_IO  (NUM_IO),
        .REGIONS (REGIONS),
        .IDX_W   (IDX_W)
    ) u_decode (
        .addr    (req_addr),
        .hit     (dec_hit),
        .onehot  (dec_onehot),
        .idx     (dec_idx),
        .offset  (dec_offset)
    );

    // Only the selected peripheral may complete the access.
    assign sel_ready = |(io_ready & io_sel);
    assign rd_slice  = io_rdata[DATA_W*int'(sel_idx) +: DATA_W];
    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);

`ifdef IO_ROUTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (state == ST_ACCESS) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end else begin
            tmo_cnt <= '0;
        end
    end

    // Counter holds the number of ACCESS cycles already completed.
    assign tmo_hit = (state == ST_ACCESS) && (tmo_cnt == CNT_W'(TIMEOUT - 1));
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (req_valid) state_nxt = dec_hit ? ST_ACCESS : ST_RESP;
            ST_ACCESS: if (sel_ready || tmo_hit) state_nxt = ST_RESP;
            ST_RESP:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_sel    <= '0;
            io_addr   <= '0;
            io_we     <= 1'b0;
            io_wdata  <= '0;
            sel_idx   <= '0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        io_sel   <= dec_onehot;
                        io_addr  <= dec_offset;
                        io_we    <= req_we;
                        io_wdata <= req_wdata;
                        sel_idx  <= dec_idx;
                        if (!dec_hit) begin
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (sel_ready) begin
                        io_sel    <= '0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= io_we ? '0 : rd_slice;
                    end else if (tmo_hit) begin
                        io_sel    <= '0;
                        rsp_err   <= 1'b1;
                        rsp_rdata <= '0;
                    end
                end
                default: io_sel <= '0;
            endcase
        end
    end

endmodule
